// File: rtl/branch_predictor.sv
// -----------------------------------------------------------------------------
// branch_predictor
//
// Direct-mapped branch target buffer with a 2-bit saturating direction counter
// per entry. Lookup of the fetch PC is combinational; resolution information
// from EX updates the table at the end of the resolving cycle and produces a
// registered mispredict/redirect request plus free-running statistics.
//
// Configuration macro:
//   BP_BYPASS_EN  when defined, a lookup whose PC (word address) matches the
//                 branch resolving in the same cycle sees the entry as it will
//                 be after that cycle's update. When undefined, lookup always
//                 sees the registered table contents.
//
// Parameters:
//   ENTRIES        number of table entries (power of 2, 4..64)
//
// Ports:
//   clk            clock, all state updates on rising edge
//   rst            asynchronous active-high reset
//   if_pc          fetch-stage PC to look up
//   pred_taken     lookup predicts taken
//   pred_target    predicted target, 0 when pred_taken is 0
//   ex_valid       a conditional branch resolves in EX this cycle
//   ex_pc          PC of the resolving branch
//   ex_realj       resolved direction (1 = taken)
//   ex_target      resolved taken target
//   ex_pred_taken  direction predicted for this branch at fetch
//   ex_pred_target target predicted for this branch at fetch
//   mispredict     registered flush/redirect request (one cycle)
//   redirect_pc    registered correct fetch PC
//   stat_branches  count of resolved branches (wraps)
//   stat_misses    count of mispredictions (wraps)
// -----------------------------------------------------------------------------
module branch_predictor #(
  parameter int unsigned ENTRIES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] if_pc,
  output logic        pred_taken,
  output logic [31:0] pred_target,
  input  logic        ex_valid,
  input  logic [31:0] ex_pc,
  input  logic        ex_realj,
  input  logic [31:0] ex_target,
  input  logic        ex_pred_taken,
  input  logic [31:0] ex_pred_target,
  output logic        mispredict,
  output logic [31:0] redirect_pc,
  output logic [31:0] stat_branches,
  output logic [31:0] stat_misses
);

  localparam int unsigned IW = $clog2(ENTRIES);
  localparam int unsigned TW = 32 - IW - 2;

  // Table storage
  logic [ENTRIES-1:0] tbl_valid;
  logic [TW-1:0]      tbl_tag    [ENTRIES];
  logic [31:0]        tbl_target [ENTRIES];
  logic [1:0]         tbl_ctr    [ENTRIES];

  // Address decomposition
  logic [IW-1:0] if_idx;
  logic [TW-1:0] if_tag;
  logic [IW-1:0] ex_idx;
  logic [TW-1:0] ex_tag;

  assign if_idx = if_pc[IW+1:2];
  assign if_tag = if_pc[31:IW+2];
  assign ex_idx = ex_pc[IW+1:2];
  assign ex_tag = ex_pc[31:IW+2];

  // Byte-offset bits of the fetch PC play no part in indexing or tagging.
  logic unused_if_pc_lsb;
  assign unused_if_pc_lsb = ^if_pc[1:0];

  // ---------------------------------------------------------------------------
  // Update path: next state of the entry addressed by ex_pc
  // ---------------------------------------------------------------------------
  logic        ex_hit;
  logic        upd_we;
  logic [31:0] upd_target;
  logic [1:0]  upd_ctr;
  logic        miss_cond;

  assign ex_hit = tbl_valid[ex_idx] && (tbl_tag[ex_idx] == ex_tag);

  always_comb begin
    upd_we     = 1'b0;
    upd_target = tbl_target[ex_idx];
    upd_ctr    = tbl_ctr[ex_idx];
    if (ex_valid) begin
      if (ex_hit) begin
        upd_we = 1'b1;
        if (ex_realj) begin
          upd_target = ex_target;
          if (upd_ctr != 2'b11) begin
            upd_ctr = upd_ctr + 2'b01;
          end
        end else if (upd_ctr != 2'b00) begin
          upd_ctr = upd_ctr - 2'b01;
        end
      end else if (ex_realj) begin
        // Allocate (or steal an aliased slot) as weakly taken.
        upd_we     = 1'b1;
        upd_target = ex_target;
        upd_ctr    = 2'b10;
      end
    end
  end

  assign miss_cond = ex_valid &&
                     ((ex_realj != ex_pred_taken) ||
                      (ex_realj && (ex_target != ex_pred_target)));

  // ---------------------------------------------------------------------------
  // Lookup path
  // ---------------------------------------------------------------------------
  logic        look_hit;
  logic [1:0]  look_ctr;
  logic [31:0] look_target;

`ifdef BP_BYPASS_EN
  // Forwarding only matters when the entry is actually written; otherwise the
  // post-update state equals the registered state.
  logic fwd;
  assign fwd = ex_valid && !rst && upd_we && (ex_pc[31:2] == if_pc[31:2]);

  always_comb begin
    look_hit    = tbl_valid[if_idx] && (tbl_tag[if_idx] == if_tag);
    look_ctr    = tbl_ctr[if_idx];
    look_target = tbl_target[if_idx];
    if (fwd) begin
      look_hit    = 1'b1;
      look_ctr    = upd_ctr;
      look_target = upd_target;
    end
  end
`else
  always_comb begin
    look_hit    = tbl_valid[if_idx] && (tbl_tag[if_idx] == if_tag);
    look_ctr    = tbl_ctr[if_idx];
    look_target = tbl_target[if_idx];
  end
`endif

  assign pred_taken  = look_hit && look_ctr[1];
  assign pred_target = pred_taken ? look_target : '0;

  // ---------------------------------------------------------------------------
  // Table state
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tbl_valid <= '0;
      for (int unsigned i = 0; i < ENTRIES; i++) begin
        tbl_tag[i]    <= '0;
        tbl_target[i] <= '0;
        tbl_ctr[i]    <= '0;
      end
    end else if (upd_we) begin
      tbl_valid[ex_idx]  <= 1'b1;
      tbl_tag[ex_idx]    <= ex_tag;
      tbl_target[ex_idx] <= upd_target;
      tbl_ctr[ex_idx]    <= upd_ctr;
    end
  end

  // ---------------------------------------------------------------------------
  // Redirect request and statistics
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mispredict    <= 1'b0;
      redirect_pc   <= '0;
      stat_branches <= '0;
      stat_misses   <= '0;
    end else begin
      mispredict <= miss_cond;
      if (ex_valid) begin
        // Not-taken resumes after the delay slot.
        redirect_pc   <= ex_realj ? ex_target : (ex_pc + 32'd8);
        stat_branches <= stat_branches + 32'd1;
      end
      if (miss_cond) begin
        stat_misses <= stat_misses + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_branch_predictor.sv
module tb_branch_predictor;

  localparam int unsigned ENTRIES = 16;
  localparam int unsigned IW      = $clog2(ENTRIES);

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] if_pc = 32'h0040_0010;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        ex_valid = 1'b0;
  logic [31:0] ex_pc = '0;
  logic        ex_realj = 1'b0;
  logic [31:0] ex_target = '0;
  logic        ex_pred_taken = 1'b0;
  logic [31:0] ex_pred_target = '0;
  logic        mispredict;
  logic [31:0] redirect_pc;
  logic [31:0] stat_branches;
  logic [31:0] stat_misses;

  branch_predictor #(.ENTRIES(ENTRIES)) dut (
    .clk            (clk),
    .rst            (rst),
    .if_pc          (if_pc),
    .pred_taken     (pred_taken),
    .pred_target    (pred_target),
    .ex_valid       (ex_valid),
    .ex_pc          (ex_pc),
    .ex_realj       (ex_realj),
    .ex_target      (ex_target),
    .ex_pred_taken  (ex_pred_taken),
    .ex_pred_target (ex_pred_target),
    .mispredict     (mispredict),
    .redirect_pc    (redirect_pc),
    .stat_branches  (stat_branches),
    .stat_misses    (stat_misses)
  );

  always #5 clk = ~clk;

  // Expected DUT view during one cycle
  typedef struct {
    logic        pt;
    logic [31:0] ptgt;
    logic        mis;
    logic [31:0] redir;
    logic [31:0] br;
    logic [31:0] miss;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;

  // Reference model: a plain table of entries plus the architectural registers
  logic        m_valid [ENTRIES];
  logic [31:0] m_tag   [ENTRIES];
  logic [31:0] m_tgt   [ENTRIES];
  int          m_ctr   [ENTRIES];
  logic        m_mis;
  logic [31:0] m_redir;
  logic [31:0] m_br;
  logic [31:0] m_miss;

  logic [31:0] pc_pool  [8];
  logic [31:0] tgt_pool [4];

  function automatic int unsigned slot(input logic [31:0] pc);
    return (pc >> 2) % ENTRIES;
  endfunction

  function automatic logic [31:0] tag_of(input logic [31:0] pc);
    return pc >> (IW + 2);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < ENTRIES; i++) begin
      m_valid[i] = 1'b0;
      m_tag[i]   = '0;
      m_tgt[i]   = '0;
      m_ctr[i]   = 0;
    end
    m_mis   = 1'b0;
    m_redir = '0;
    m_br    = '0;
    m_miss  = '0;
  endtask

  task automatic model_lookup(input logic [31:0] pc, output logic t, output logic [31:0] tg);
    int unsigned s;
    s  = slot(pc);
    t  = m_valid[s] && (m_tag[s] == tag_of(pc)) && (m_ctr[s] >= 2);
    tg = t ? m_tgt[s] : 32'h0;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  // Drive one cycle of stimulus, record what the DUT should show this cycle,
  // then advance the model across the coming clock edge.
  task automatic apply(input logic [31:0] ipc, input logic v, input logic [31:0] pc,
                       input logic rj, input logic [31:0] tgt,
                       input logic pt, input logic [31:0] ptgt);
    exp_t        e;
    int unsigned s;
    logic        mc;
    if_pc          = ipc;
    ex_valid       = v;
    ex_pc          = pc;
    ex_realj       = rj;
    ex_target      = tgt;
    ex_pred_taken  = pt;
    ex_pred_target = ptgt;
    model_lookup(ipc, e.pt, e.ptgt);
    e.mis   = m_mis;
    e.redir = m_redir;
    e.br    = m_br;
    e.miss  = m_miss;
    m_mis   = 1'b0;
    if (v) begin
      mc      = (rj != pt) || (rj && (tgt != ptgt));
      m_mis   = mc;
      m_redir = rj ? tgt : pc + 32'd8;
      m_br    = m_br + 32'd1;
      if (mc) m_miss = m_miss + 32'd1;
      s = slot(pc);
      if (m_valid[s] && (m_tag[s] == tag_of(pc))) begin
        if (rj) begin
          m_ctr[s] = (m_ctr[s] == 3) ? 3 : m_ctr[s] + 1;
          m_tgt[s] = tgt;
        end else begin
          m_ctr[s] = (m_ctr[s] == 0) ? 0 : m_ctr[s] - 1;
        end
      end else if (rj) begin
        m_valid[s] = 1'b1;
        m_tag[s]   = tag_of(pc);
        m_tgt[s]   = tgt;
        m_ctr[s]   = 2;
      end
`ifdef BP_BYPASS_EN
      if ((ipc >> 2) == (pc >> 2)) model_lookup(ipc, e.pt, e.ptgt);
`endif
    end
    sb.push_back(e);
  endtask

  task automatic step(input logic [31:0] ipc, input logic v, input logic [31:0] pc,
                      input logic rj, input logic [31:0] tgt,
                      input logic pt, input logic [31:0] ptgt);
    @(posedge clk);
    #1;
    apply(ipc, v, pc, rj, tgt, pt, ptgt);
  endtask

  task automatic idle(input logic [31:0] ipc);
    step(ipc, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
  endtask

  // Monitor: compare every cycle that has a pending expectation
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("pred_taken",    {31'b0, pred_taken}, {31'b0, e.pt});
        chk("pred_target",   pred_target,         e.ptgt);
        chk("mispredict",    {31'b0, mispredict}, {31'b0, e.mis});
        chk("redirect_pc",   redirect_pc,         e.redir);
        chk("stat_branches", stat_branches,       e.br);
        chk("stat_misses",   stat_misses,         e.miss);
      end
    end
  end

  // Watchdog
  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic        exp_byp;
    logic [31:0] pc, ipc, tgt, ptgt;
    logic        v, rj, pt, mt;
    logic [31:0] mtg;

    pc_pool[0] = 32'h0040_0010; pc_pool[1] = 32'h0040_0014;
    pc_pool[2] = 32'h0040_0020; pc_pool[3] = 32'h0080_0010;
    pc_pool[4] = 32'h0040_0050; pc_pool[5] = 32'h00c0_0014;
    pc_pool[6] = 32'h0040_0110; pc_pool[7] = 32'h0040_003c;
    tgt_pool[0] = 32'h0040_0100; tgt_pool[1] = 32'h0040_0200;
    tgt_pool[2] = 32'h0080_0200; tgt_pool[3] = 32'h0040_1000;
`ifdef BP_BYPASS_EN
    exp_byp = 1'b1;
`else
    exp_byp = 1'b0;
`endif

    // Reset state
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_pred_taken",    {31'b0, pred_taken}, 32'h0);
    chk("rst_pred_target",   pred_target,         32'h0);
    chk("rst_mispredict",    {31'b0, mispredict}, 32'h0);
    chk("rst_redirect_pc",   redirect_pc,         32'h0);
    chk("rst_stat_branches", stat_branches,       32'h0);
    chk("rst_stat_misses",   stat_misses,         32'h0);

    // First taken resolution, issued in the very cycle reset is released
    @(posedge clk);
    #1;
    rst = 1'b0;
    apply(32'h0040_0010, 1'b1, 32'h0040_0010, 1'b1, 32'h0040_0100, 1'b0, 32'h0);
    idle(32'h0040_0010);
    @(negedge clk); #1;
    chk("alloc_mispredict",  {31'b0, mispredict}, 32'h1);
    chk("alloc_redirect",    redirect_pc,         32'h0040_0100);
    chk("alloc_pred_taken",  {31'b0, pred_taken}, 32'h1);
    chk("alloc_pred_target", pred_target,         32'h0040_0100);
    chk("alloc_misses",      stat_misses,         32'h1);

    // Two not-taken resolutions: counter 2 -> 1 -> 0
    step(32'h0040_0010, 1'b1, 32'h0040_0010, 1'b0, 32'h0, 1'b1, 32'h0040_0100);
    step(32'h0040_0010, 1'b1, 32'h0040_0010, 1'b0, 32'h0, 1'b0, 32'h0);
    @(negedge clk); #1;
    chk("nt_mispredict", {31'b0, mispredict}, 32'h1);
    chk("nt_redirect",   redirect_pc,         32'h0040_0018);
    idle(32'h0040_0010);
    @(negedge clk); #1;
    chk("nt2_mispredict", {31'b0, mispredict}, 32'h0);
    chk("nt2_branches",   stat_branches,       32'h3);
    chk("nt2_pred_taken", {31'b0, pred_taken}, 32'h0);

    // Saturation: four taken, then one not-taken still predicts taken
    for (int i = 0; i < 4; i++)
      step(32'h0040_0010, 1'b1, 32'h0040_0010, 1'b1, 32'h0040_0100, 1'b1, 32'h0040_0100);
    step(32'h0040_0010, 1'b1, 32'h0040_0010, 1'b0, 32'h0, 1'b1, 32'h0040_0100);
    idle(32'h0040_0010);
    @(negedge clk); #1;
    chk("sat_pred_taken", {31'b0, pred_taken}, 32'h1);

    // Aliasing: same index, different tag overwrites
    step(32'h0040_0010, 1'b1, 32'h0080_0010, 1'b1, 32'h0080_0200, 1'b0, 32'h0);
    idle(32'h0040_0010);
    @(negedge clk); #1;
    chk("alias_old_taken", {31'b0, pred_taken}, 32'h0);
    idle(32'h0080_0010);
    @(negedge clk); #1;
    chk("alias_new_target", pred_target, 32'h0080_0200);

    // Same-cycle lookup of a freshly resolving taken branch
    step(32'h0040_0024, 1'b1, 32'h0040_0024, 1'b1, 32'h0040_0300, 1'b0, 32'h0);
    @(negedge clk); #1;
    chk("bypass_pred_taken", {31'b0, pred_taken}, {31'b0, exp_byp});
    idle(32'h0040_0024);
    @(negedge clk); #1;
    chk("pre_rst_mispredict", {31'b0, mispredict}, 32'h1);
    rst = 1'b1;
    #1;
    chk("async_rst_mispredict", {31'b0, mispredict}, 32'h0);
    chk("async_rst_pred_taken", {31'b0, pred_taken}, 32'h0);
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    apply(32'h0040_0024, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);

    // Randomized traffic over an aliasing-rich PC pool
    for (int n = 0; n < 3000; n++) begin
      pc  = pc_pool[$urandom_range(0, 7)];
      ipc = ($urandom_range(0, 9) < 3) ? pc : pc_pool[$urandom_range(0, 7)];
      v   = ($urandom_range(0, 9) < 7);
      rj  = $urandom_range(0, 1);
      tgt = tgt_pool[$urandom_range(0, 3)];
      model_lookup(pc, mt, mtg);
      if ($urandom_range(0, 9) < 6) begin
        pt   = mt;
        ptgt = mtg;
      end else begin
        pt   = $urandom_range(0, 1);
        ptgt = pt ? tgt_pool[$urandom_range(0, 3)] : 32'h0;
      end
      step(ipc, v, pc, rj, tgt, pt, ptgt);
    end
    idle(32'h0040_0010);

    // Drain, bounded
    repeat (3) @(posedge clk);
    n_cmp++;
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL drain: got %0d pending expected 0", sb.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
